spi_reg_ctrl: RTL and testbench

- Command/register sequencer behind the SPI slave word engine. Interprets the word stream of each SPI frame (ss low) as a command word followed by data words.
- Drives a single-master register bus with a req/ack handshake, with address auto-increment for bursts.
- Supplies the transmit word the slave loads at each word boundary. Gives the host read/write access to the acquisition register file.

---
 rtl/spi_reg_ctrl.sv | 132 +++++++++++++
 tb/tb_spi_reg_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// Turns each SPI frame's word stream into register bus reads/writes with address auto-increment.
// Bus requests are issued the cycle after word_done; read data reaches word_tx the cycle after reg_ack.
// Requests issued while one is still outstanding are dropped and set the sticky ovr_err flag.
module spi_reg_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] ERR_WORD   = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic                  word_done,
    input  logic [DATA_WIDTH-1:0] word_rx,
    output logic [DATA_WIDTH-1:0] word_tx,
    output logic                  reg_req,
    output logic                  reg_we,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack,
    output logic                  busy,
    output logic                  ovr_err
);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} frame_state_t;
    typedef enum logic {BUS_IDLE, BUS_REQ} bus_state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    frame_state_t          frame_state, frame_next;
    bus_state_t            bus_state, bus_next;
    logic                  ss_m, ss_s, ss_d;
    logic                  frame_start;
    logic [ADDR_WIDTH-1:0] addr_ptr, addr_next, cmd_addr;
    logic                  issue, issue_we;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_wdata;
    logic                  ack_now, accept, overrun;

    assign frame_start = ss_d & ~ss_s;
    assign cmd_addr    = word_rx[ADDR_WIDTH-1:0];

    always_comb begin
        frame_next  = frame_state;
        addr_next   = addr_ptr;
        issue       = 1'b0;
        issue_we    = 1'b0;
        issue_addr  = addr_ptr;
        issue_wdata = word_rx;
        if (frame_state != IDLE && ss_s) begin
            frame_next = IDLE;
        end else begin
            case (frame_state)
                IDLE: if (frame_start) frame_next = CMD;
                CMD: if (word_done) begin
                    addr_next = cmd_addr;
                    if (word_rx[DATA_WIDTH-1]) begin
                        frame_next = RD;
                        issue      = 1'b1;
                        issue_addr = cmd_addr;
                        addr_next  = cmd_addr + ADDR_ONE;
                    end else begin
                        frame_next = WR;
                    end
                end
                WR: if (word_done) begin
                    issue     = 1'b1;
                    issue_we  = 1'b1;
                    addr_next = addr_ptr + ADDR_ONE;
                end
                RD: if (word_done) begin
                    issue     = 1'b1;
                    addr_next = addr_ptr + ADDR_ONE;
                end
                default: frame_next = IDLE;
            endcase
        end
    end

    // An ack in the same cycle frees the bus, so a coincident issue is accepted.
    always_comb begin
        ack_now  = (bus_state == BUS_REQ) && reg_ack;
        accept   = issue && ((bus_state == BUS_IDLE) || ack_now);
        overrun  = issue && !accept;
        bus_next = bus_state;
        if (accept)       bus_next = BUS_REQ;
        else if (ack_now) bus_next = BUS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_m        <= 1'b1;
            ss_s        <= 1'b1;
            ss_d        <= 1'b1;
            frame_state <= IDLE;
            bus_state   <= BUS_IDLE;
            addr_ptr    <= '0;
            word_tx     <= '0;
            reg_req     <= 1'b0;
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            ovr_err     <= 1'b0;
        end else begin
            ss_m        <= ss;
            ss_s        <= ss_m;
            ss_d        <= ss_s;
            frame_state <= frame_next;
            bus_state   <= bus_next;
            addr_ptr    <= addr_next;
            if (accept) begin
                reg_req   <= 1'b1;
                reg_we    <= issue_we;
                reg_addr  <= issue_addr;
                reg_wdata <= issue_wdata;
            end else if (ack_now) begin
                reg_req <= 1'b0;
            end
            if (overrun) ovr_err <= 1'b1;
            // The host sees ERR_WORD in the slot a dropped read would have filled.
            if (overrun && !issue_we)
                word_tx <= ERR_WORD;
            else if (ack_now && !reg_we)
                word_tx <= reg_rdata;
            else if (frame_state == IDLE && frame_start)
                word_tx <= '0;
        end
    end

    assign busy = (frame_state != IDLE) || (bus_state == BUS_REQ);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: SPI word stream stimulus plus a logging register-bus responder.
module tb_spi_reg_ctrl;

    logic        clk, rst, ss, word_done;
    logic [15:0] word_rx, word_tx, reg_wdata, reg_rdata;
    logic        reg_req, reg_we, reg_ack, busy, ovr_err;
    logic [6:0]  reg_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        auto_ack = 1'b0;
    int          ack_dly  = 1;
    int          resp_cnt = 0;
    int          log_n    = 0;
    logic        log_we    [64];
    logic [6:0]  log_addr  [64];
    logic [15:0] log_wdata [64];

    spi_reg_ctrl dut (
        .clk(clk), .rst(rst), .ss(ss), .word_done(word_done), .word_rx(word_rx),
        .word_tx(word_tx), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .busy(busy), .ovr_err(ovr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus slave: acks ack_dly cycles after seeing reg_req, returns 0xA000+addr, logs each ack.
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #2;
            reg_ack = 1'b0;
            if (reg_req && auto_ack) begin
                if (resp_cnt >= ack_dly) begin
                    reg_ack          = 1'b1;
                    reg_rdata        = 16'hA000 | {9'd0, reg_addr};
                    log_we[log_n]    = reg_we;
                    log_addr[log_n]  = reg_addr;
                    log_wdata[log_n] = reg_wdata;
                    log_n++;
                    resp_cnt = 0;
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Returns the word_tx value the slave would load at this word boundary.
    task automatic send_word(input logic [15:0] w, output logic [15:0] cap);
        @(negedge clk);
        cap       = word_tx;
        word_rx   = w;
        word_done = 1'b1;
        @(negedge clk);
        word_done = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] cap;
        int base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({reg_req, reg_we, busy, ovr_err} !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {reg_req, reg_we, busy, ovr_err}); end
        n_checks++; if ({word_tx, reg_addr, reg_wdata} !== 39'd0) begin n_fail++;
            $display("FAIL reset_buses: got tx=%h addr=%h wdata=%h want 0", word_tx, reg_addr, reg_wdata); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        base = log_n;
        send_word(16'h8001, cap);
        n_checks++; if ({reg_req, busy} !== 2'b00 || log_n != base) begin n_fail++;
            $display("FAIL idle_word_done: got req=%b busy=%b txns=%0d want 0 0 0", reg_req, busy, log_n - base); end
    endtask

    task automatic test_write_burst();
        logic [15:0] cap;
        logic [6:0]  ea [3];
        logic [15:0] ed [3];
        int base;
        ea[0] = 7'h05; ea[1] = 7'h06; ea[2] = 7'h07;
        ed[0] = 16'h1111; ed[1] = 16'h2222; ed[2] = 16'h3333;
        auto_ack = 1'b1; ack_dly = 2; base = log_n;
        start_frame();
        send_word(16'h0005, cap);
        for (int i = 0; i < 3; i++) send_word(ed[i], cap);
        end_frame();
        n_checks++; if (log_n != base + 3) begin n_fail++;
            $display("FAIL wr_count: got %0d want 3", log_n - base); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({log_we[base+i], log_addr[base+i], log_wdata[base+i]} !== {1'b1, ea[i], ed[i]}) begin n_fail++;
                $display("FAIL wr_txn%0d: got we=%b addr=%h data=%h want 1 %h %h", i,
                         log_we[base+i], log_addr[base+i], log_wdata[base+i], ea[i], ed[i]); end
        end
        n_checks++; if ({ovr_err, busy} !== 2'b00) begin n_fail++;
            $display("FAIL wr_flags: got ovr=%b busy=%b want 0 0", ovr_err, busy); end
    endtask

    task automatic test_read_burst();
        logic [15:0] cap [4];
        logic [15:0] exp_tx [4];
        int base;
        exp_tx[0] = 16'h0000; exp_tx[1] = 16'hA010; exp_tx[2] = 16'hA011; exp_tx[3] = 16'hA012;
        auto_ack = 1'b1; ack_dly = 1; base = log_n;
        start_frame();
        send_word(16'h8010, cap[0]);
        for (int i = 1; i < 4; i++) send_word(16'h0000, cap[i]);
        end_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap[i] !== exp_tx[i]) begin n_fail++;
                $display("FAIL rd_word%0d: got %h want %h", i, cap[i], exp_tx[i]); end
        end
        n_checks++; if (log_n != base + 4 || log_we[base] !== 1'b0 || log_addr[base+3] !== 7'h13) begin n_fail++;
            $display("FAIL rd_txns: got n=%0d we0=%b addr3=%h want 4 0 13", log_n - base, log_we[base], log_addr[base+3]); end
    endtask

    task automatic test_wrap();
        logic [15:0] cap;
        int base;
        auto_ack = 1'b1; ack_dly = 1; base = log_n;
        start_frame();
        send_word(16'h007F, cap);
        send_word(16'hAAAA, cap);
        send_word(16'hBBBB, cap);
        end_frame();
        n_checks++; if (log_n != base + 2 || log_addr[base] !== 7'h7F || log_addr[base+1] !== 7'h00) begin n_fail++;
            $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h want 2 7f 00", log_n - base, log_addr[base], log_addr[base+1]); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] cap;
        int base;
        auto_ack = 1'b0; base = log_n;
        start_frame();
        send_word(16'h0040, cap);
        send_word(16'h1234, cap);
        auto_ack = 1'b1; ack_dly = 0;
        @(negedge clk);
        word_rx = 16'h5678; word_done = 1'b1; auto_ack = 1'b0;
        @(negedge clk);
        word_done = 1'b0;
        n_checks++; if ({reg_req, reg_we, reg_addr, reg_wdata} !== {1'b1, 1'b1, 7'h41, 16'h5678}) begin n_fail++;
            $display("FAIL simul_req: got req=%b we=%b addr=%h data=%h want 1 1 41 5678", reg_req, reg_we, reg_addr, reg_wdata); end
        n_checks++; if (ovr_err !== 1'b0) begin n_fail++;
            $display("FAIL simul_ovr: got %b want 0", ovr_err); end
        auto_ack = 1'b1;
        repeat (4) @(negedge clk);
        end_frame();
        n_checks++; if (log_n != base + 2 || log_addr[base] !== 7'h40 || log_addr[base+1] !== 7'h41) begin n_fail++;
            $display("FAIL simul_txns: got n=%0d a0=%h a1=%h want 2 40 41", log_n - base, log_addr[base], log_addr[base+1]); end
    endtask

    task automatic test_abort();
        logic [15:0] cap;
        logic got;
        auto_ack = 1'b0; got = 1'b0;
        start_frame();
        send_word(16'h0030, cap);
        send_word(16'h5555, cap);
        end_frame();
        n_checks++; if ({reg_req, busy, reg_addr, reg_wdata} !== {1'b1, 1'b1, 7'h30, 16'h5555}) begin n_fail++;
            $display("FAIL abort_held: got req=%b busy=%b addr=%h data=%h want 1 1 30 5555", reg_req, busy, reg_addr, reg_wdata); end
        auto_ack = 1'b1; ack_dly = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (reg_ack) begin got = 1'b1; break; end
        end
        n_checks++; if (got !== 1'b1) begin n_fail++;
            $display("FAIL abort_ack_timeout: got ack=%b want 1", got); end
        @(negedge clk);
        n_checks++; if ({reg_req, busy} !== 2'b00) begin n_fail++;
            $display("FAIL abort_release: got req=%b busy=%b want 0 0", reg_req, busy); end
    endtask

    task automatic test_overrun();
        logic [15:0] cap;
        int base;
        auto_ack = 1'b0; base = log_n;
        start_frame();
        send_word(16'h8020, cap);
        send_word(16'h0000, cap);
        n_checks++; if ({ovr_err, word_tx} !== {1'b1, 16'hFFFF}) begin n_fail++;
            $display("FAIL ovr_flag_tx: got ovr=%b tx=%h want 1 ffff", ovr_err, word_tx); end
        n_checks++; if ({reg_req, reg_we, reg_addr} !== {1'b1, 1'b0, 7'h20}) begin n_fail++;
            $display("FAIL ovr_pending: got req=%b we=%b addr=%h want 1 0 20", reg_req, reg_we, reg_addr); end
        auto_ack = 1'b1; ack_dly = 0;
        repeat (4) @(negedge clk);
        n_checks++; if (log_n != base + 1 || log_addr[base] !== 7'h20 || word_tx !== 16'hA020 || reg_req !== 1'b0) begin n_fail++;
            $display("FAIL ovr_complete: got n=%0d addr=%h tx=%h req=%b want 1 20 a020 0", log_n - base, log_addr[base], word_tx, reg_req); end
        end_frame();
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] cap;
        int base;
        auto_ack = 1'b0;
        start_frame();
        send_word(16'h0050, cap);
        send_word(16'h9999, cap);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({reg_req, reg_we, busy, ovr_err} !== 4'b0 || {word_tx, reg_addr, reg_wdata} !== 39'd0) begin n_fail++;
            $display("FAIL rst_mid: got req=%b we=%b busy=%b ovr=%b tx=%h addr=%h data=%h want all 0",
                     reg_req, reg_we, busy, ovr_err, word_tx, reg_addr, reg_wdata); end
        end_frame();
        auto_ack = 1'b1; ack_dly = 1; base = log_n;
        start_frame();
        send_word(16'h0060, cap);
        send_word(16'hBEEF, cap);
        end_frame();
        n_checks++; if (log_n != base + 1 || {log_we[base], log_addr[base], log_wdata[base]} !== {1'b1, 7'h60, 16'hBEEF}) begin n_fail++;
            $display("FAIL rst_after_frame: got n=%0d we=%b addr=%h data=%h want 1 1 60 beef",
                     log_n - base, log_we[base], log_addr[base], log_wdata[base]); end
        n_checks++; if ({ovr_err, busy} !== 2'b00) begin n_fail++;
            $display("FAIL rst_after_flags: got ovr=%b busy=%b want 0 0", ovr_err, busy); end
    endtask

    initial begin
        rst = 1'b1; ss = 1'b1; word_done = 1'b0; word_rx = 16'h0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_simultaneous();
        test_abort();
        test_overrun();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
